// File: rtl/bk_pkg.sv
// Shared types and constants for the backup-RAM SD persistence controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: controller state enum, HuBM default-word table, format word count.
package bk_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FMT,
      ST_REQ,
      ST_XFER,
      ST_NEXT
   } state_t;

   localparam int FMT_WORDS = 4;

   // HuBM header written to the first four backup-RAM words on format.
   localparam logic [15:0] FMT_WORD [FMT_WORDS] = '{16'h5548, 16'h4D42, 16'h8800, 16'h8010};

endpackage

// File: rtl/bk_sd_ctrl_edge_det.sv
// Parameterised N-bit rising-edge detector on level inputs.
// Latency: rise is combinational from level, one register of history.
// Backpressure: none; history updates every cycle, including during reset.
// Ports: clk (clock), level (N input levels), rise (N one-cycle edge flags).
module edge_det #(
   parameter int N = 1
) (
   input  logic         clk,
   input  logic [N-1:0] level,
   output logic [N-1:0] rise
);

   logic [N-1:0] prev;

   // No reset: a level held high through reset must not look like a new edge.
   always_ff @(posedge clk) begin
      prev <= level;
   end

   assign rise = level & ~prev;

endmodule

// File: rtl/bk_sd_ctrl.sv
// Backup-RAM persistence: OSD load/save/format commands to SD sector transfers and HuBM init.
// Latency: request edge -> sd_rd/sd_wr + sd_lba next cycle; format edge -> 4 RAM writes, done on the 5th cycle.
// Backpressure: waits on sd_ack per sector; new load/save edges while busy are dropped, format is held pending.
// Ports: clk_sys/reset; bk_ena, load_req/save_req/format_req, slot, bram_wr in;
//        sd_lba/sd_rd/sd_wr out + sd_ack in toward hps_io; fmt_we/fmt_addr/fmt_data to RAM port B;
//        bk_loading, bk_busy, bk_dirty, bk_done status out.
module bk_sd_ctrl
   import bk_pkg::*;
#(
   parameter int SECTORS = 16,
   parameter int SLOT_W  = 2
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              bk_ena,
   input  logic              load_req,
   input  logic              save_req,
   input  logic              format_req,
   input  logic [SLOT_W-1:0] slot,
   input  logic              bram_wr,
   output logic [31:0]       sd_lba,
   output logic              sd_rd,
   output logic              sd_wr,
   input  logic              sd_ack,
   output logic              fmt_we,
   output logic [1:0]        fmt_addr,
   output logic [15:0]       fmt_data,
   output logic              bk_loading,
   output logic              bk_busy,
   output logic              bk_dirty,
   output logic              bk_done
);

   localparam int SEC_W = $clog2(SECTORS);

   state_t            state, state_nx;
   logic [SLOT_W-1:0] slot_q, slot_nx;
   logic [SEC_W-1:0]  sec_q, sec_nx;
   logic              op_load, op_load_nx;
   logic              rd_nx, wr_nx;
   logic              fmt_we_nx;
   logic [1:0]        fmt_addr_nx;
   logic [15:0]       fmt_data_nx;
   logic              loading_nx, done_nx, dirty_nx;
   logic              pend_q, pend_nx;
   logic              dirty_clr, dirty_set;
   logic              ack_q, ack_rise, ack_fall;
   logic [2:0]        rise;
   logic              fmt_rise, load_rise, save_rise;

   edge_det #(.N(3)) u_edge (
      .clk   (clk_sys),
      .level ({format_req, load_req, save_req}),
      .rise  (rise)
   );

   assign fmt_rise  = rise[2];
   assign load_rise = rise[1];
   assign save_rise = rise[0];

   // sd_ack history is not reset so a sector still completing across a reset
   // cannot fake a rising edge for the next command.
   always_ff @(posedge clk_sys) begin
      ack_q <= sd_ack;
   end

   assign ack_rise = sd_ack & ~ack_q;
   assign ack_fall = ~sd_ack & ack_q;

   // Slot in the upper field, sector index in the low field; no carry between them.
   assign sd_lba  = {{(32 - SLOT_W - SEC_W){1'b0}}, slot_q, sec_q};
   assign bk_busy = (state != ST_IDLE) | pend_q;

   always_comb begin
      state_nx    = state;
      slot_nx     = slot_q;
      sec_nx      = sec_q;
      op_load_nx  = op_load;
      rd_nx       = sd_rd;
      wr_nx       = sd_wr;
      fmt_we_nx   = 1'b0;
      fmt_addr_nx = fmt_addr;
      fmt_data_nx = fmt_data;
      loading_nx  = bk_loading;
      done_nx     = 1'b0;
      pend_nx     = pend_q;
      dirty_clr   = 1'b0;
      dirty_set   = bram_wr;

      case (state)
         ST_IDLE: begin
            // Format wins over load, load over save; losing edges are discarded.
            if (fmt_rise || pend_q) begin
               state_nx    = ST_FMT;
               pend_nx     = 1'b0;
               fmt_we_nx   = 1'b1;
               fmt_addr_nx = 2'd0;
               fmt_data_nx = FMT_WORD[0];
            end else if (bk_ena && (load_rise || save_rise)) begin
               state_nx   = ST_REQ;
               op_load_nx = load_rise;
               slot_nx    = slot;
               sec_nx     = '0;
               rd_nx      = load_rise;
               wr_nx      = ~load_rise;
               loading_nx = load_rise;
               dirty_clr  = ~load_rise;
            end
         end
         ST_FMT: begin
            if (fmt_addr == 2'(FMT_WORDS - 1)) begin
               state_nx    = ST_IDLE;
               done_nx     = 1'b1;
               dirty_set   = 1'b1;
               fmt_addr_nx = 2'd0;
               fmt_data_nx = 16'h0000;
            end else begin
               fmt_we_nx   = 1'b1;
               fmt_addr_nx = fmt_addr + 2'd1;
               fmt_data_nx = FMT_WORD[fmt_addr + 2'd1];
            end
         end
         ST_REQ: begin
            if (ack_rise) begin
               rd_nx    = 1'b0;
               wr_nx    = 1'b0;
               state_nx = ST_XFER;
            end
         end
         ST_XFER: begin
            if (ack_fall) begin
               state_nx = ST_NEXT;
            end
         end
         ST_NEXT: begin
            // Losing bk_ena ends the transfer at the sector boundary.
            if ((&sec_q) || !bk_ena) begin
               state_nx   = ST_IDLE;
               done_nx    = 1'b1;
               loading_nx = 1'b0;
               dirty_clr  = op_load;
            end else begin
               sec_nx   = sec_q + SEC_W'(1);
               rd_nx    = op_load;
               wr_nx    = ~op_load;
               state_nx = ST_REQ;
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase

      if (fmt_rise && (state == ST_REQ || state == ST_XFER || state == ST_NEXT)) begin
         pend_nx = 1'b1;
      end

      // A RAM write in the same cycle as a clear keeps the image dirty.
      if (dirty_set) begin
         dirty_nx = 1'b1;
      end else if (dirty_clr) begin
         dirty_nx = 1'b0;
      end else begin
         dirty_nx = bk_dirty;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state      <= ST_IDLE;
         slot_q     <= '0;
         sec_q      <= '0;
         op_load    <= 1'b0;
         sd_rd      <= 1'b0;
         sd_wr      <= 1'b0;
         fmt_we     <= 1'b0;
         fmt_addr   <= 2'd0;
         fmt_data   <= 16'h0000;
         bk_loading <= 1'b0;
         bk_dirty   <= 1'b0;
         bk_done    <= 1'b0;
         pend_q     <= 1'b0;
      end else begin
         state      <= state_nx;
         slot_q     <= slot_nx;
         sec_q      <= sec_nx;
         op_load    <= op_load_nx;
         sd_rd      <= rd_nx;
         sd_wr      <= wr_nx;
         fmt_we     <= fmt_we_nx;
         fmt_addr   <= fmt_addr_nx;
         fmt_data   <= fmt_data_nx;
         bk_loading <= loading_nx;
         bk_dirty   <= dirty_nx;
         bk_done    <= done_nx;
         pend_q     <= pend_nx;
      end
   end

endmodule

// File: tb/tb_bk_sd_ctrl.sv
// Self-checking bench for bk_sd_ctrl with a randomized hps_io sector model.
// Latency: n/a.
// Backpressure: n/a.
module tb_bk_sd_ctrl;

   localparam int SECTORS = 16;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic        bk_ena = 1'b0;
   logic        load_req = 1'b0;
   logic        save_req = 1'b0;
   logic        format_req = 1'b0;
   logic [1:0]  slot = 2'd0;
   logic        bram_wr = 1'b0;
   logic [31:0] sd_lba;
   logic        sd_rd;
   logic        sd_wr;
   logic        sd_ack = 1'b0;
   logic        fmt_we;
   logic [1:0]  fmt_addr;
   logic [15:0] fmt_data;
   logic        bk_loading;
   logic        bk_busy;
   logic        bk_dirty;
   logic        bk_done;

   bk_sd_ctrl #(.SECTORS(SECTORS), .SLOT_W(2)) dut (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .bk_ena     (bk_ena),
      .load_req   (load_req),
      .save_req   (save_req),
      .format_req (format_req),
      .slot       (slot),
      .bram_wr    (bram_wr),
      .sd_lba     (sd_lba),
      .sd_rd      (sd_rd),
      .sd_wr      (sd_wr),
      .sd_ack     (sd_ack),
      .fmt_we     (fmt_we),
      .fmt_addr   (fmt_addr),
      .fmt_data   (fmt_data),
      .bk_loading (bk_loading),
      .bk_busy    (bk_busy),
      .bk_dirty   (bk_dirty),
      .bk_done    (bk_done)
   );

   always #5 clk_sys = ~clk_sys;

   // HuBM header the RAM must receive on format.
   logic [15:0] hdr_words [4] = '{16'h5548, 16'h4D42, 16'h8800, 16'h8010};

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- hps_io model: records every sector request ----------------
   bit          rec_wr[$];
   logic [31:0] rec_lba[$];
   int          lat_bad = 0;   // request still high the cycle after ack rose
   int          gap_bad = 0;   // ack fall -> next request/done not exactly two cycles later
   bit          hps_chk = 1'b1;
   int          ack_len_fix = 0;

   initial begin : hps_model
      int since, dly, len;
      bit pend;
      since = 0;
      pend  = 1'b0;
      forever begin
         @(negedge clk_sys);
         if (pend) begin
            since++;
            if (since == 1 && (sd_rd || sd_wr) && hps_chk) gap_bad++;
            if (since == 2) begin
               pend = 1'b0;
               if (hps_chk && !(sd_rd || sd_wr || bk_done)) gap_bad++;
            end
         end
         if ((sd_rd || sd_wr) && !reset) begin
            rec_wr.push_back(sd_wr);
            rec_lba.push_back(sd_lba);
            dly = $urandom_range(0, 3);
            len = (ack_len_fix > 0) ? ack_len_fix : $urandom_range(1, 10);
            repeat (dly) @(negedge clk_sys);
            sd_ack = 1'b1;
            @(negedge clk_sys);
            if ((sd_rd || sd_wr) && hps_chk) lat_bad++;
            repeat (len - 1) @(negedge clk_sys);
            sd_ack = 1'b0;
            pend  = 1'b1;
            since = 0;
         end
      end
   end

   // ---------------- event counters ----------------
   int done_cnt = 0;
   int busy_cnt = 0;
   int we_cnt   = 0;
   always @(posedge clk_sys) begin
      if (bk_done) done_cnt++;
      if (bk_busy) busy_cnt++;
      if (fmt_we)  we_cnt++;
   end

   // Runs until bk_done, optionally firing one stimulus when the hps model
   // has seen hook_at sector requests (1: bram_wr pulse, 2: format edge, 3: drop bk_ena).
   task automatic run_op(input int budget, input int hook_at, input int hook_kind,
                         input bit is_load, output int load_low);
      bit fired;
      int n;
      fired    = 1'b0;
      n        = 0;
      load_low = 0;
      forever begin
         @(negedge clk_sys);
         bram_wr    = 1'b0;
         format_req = 1'b0;
         if (bk_done) break;
         if (is_load && !bk_loading) load_low++;
         if (!fired && rec_lba.size() == hook_at) begin
            fired = 1'b1;
            case (hook_kind)
               1: bram_wr = 1'b1;
               2: format_req = 1'b1;
               3: bk_ena = 1'b0;
               default: ;
            endcase
         end
         n++;
         if (n > budget) begin
            chk("op_done_timeout", bk_done, 1);
            break;
         end
      end
   endtask

   // Called on the negedge where the format edge is being presented (or the
   // negedge of the previous bk_done for a pending format).
   task automatic check_fmt(input string tag);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_sys);
         chk({tag, "_we"}, fmt_we, 1);
         chk({tag, "_addr"}, fmt_addr, i);
         chk({tag, "_data"}, fmt_data, hdr_words[i]);
      end
      @(negedge clk_sys);
      chk({tag, "_done"}, bk_done, 1);
      chk({tag, "_we_off"}, fmt_we, 0);
   endtask

   task automatic check_seq(input string tag, input int exp_n, input bit exp_wr, input int exp_slot);
      chk({tag, "_count"}, rec_lba.size(), exp_n);
      for (int i = 0; i < rec_lba.size(); i++) begin
         chk({tag, "_lba"}, rec_lba[i], exp_slot * SECTORS + i);
         chk({tag, "_dir"}, rec_wr[i], exp_wr);
      end
   endtask

   initial begin : main
      int ll, d0, b0, w0, s;

      // ---- reset state ----
      repeat (3) @(negedge clk_sys);
      chk("rst_lba", sd_lba, 0);
      chk("rst_rd", sd_rd, 0);
      chk("rst_wr", sd_wr, 0);
      chk("rst_fmt_we", fmt_we, 0);
      chk("rst_fmt_addr", fmt_addr, 0);
      chk("rst_fmt_data", fmt_data, 0);
      chk("rst_loading", bk_loading, 0);
      chk("rst_busy", bk_busy, 0);
      chk("rst_dirty", bk_dirty, 0);
      chk("rst_done", bk_done, 0);
      reset = 1'b0;
      bk_ena = 1'b1;
      @(negedge clk_sys);

      // ---- RAM write marks image dirty ----
      bram_wr = 1'b1;
      @(negedge clk_sys);
      bram_wr = 1'b0;
      chk("dirty_by_write", bk_dirty, 1);

      // ---- load slot 2, 8-cycle acks ----
      ack_len_fix = 8;
      rec_wr.delete(); rec_lba.delete();
      d0 = done_cnt;
      slot = 2'd2;
      load_req = 1'b1;
      @(negedge clk_sys);
      chk("load_first_rd", sd_rd, 1);
      chk("load_first_lba", sd_lba, 32'h20);
      chk("load_first_wr", sd_wr, 0);
      load_req = 1'b0;
      run_op(3000, -1, 0, 1'b1, ll);
      repeat (4) @(negedge clk_sys);
      check_seq("load", 16, 1'b0, 2);
      chk("load_loading_low", ll, 0);
      chk("load_done_pulses", done_cnt - d0, 1);
      chk("load_dirty", bk_dirty, 0);
      chk("load_busy_after", bk_busy, 0);
      ack_len_fix = 0;

      // ---- save with bk_ena low is ignored ----
      bk_ena = 1'b0;
      rec_wr.delete(); rec_lba.delete();
      b0 = busy_cnt;
      d0 = done_cnt;
      save_req = 1'b1;
      repeat (20) @(negedge clk_sys);
      save_req = 1'b0;
      chk("noena_reqs", rec_lba.size(), 0);
      chk("noena_busy", busy_cnt - b0, 0);
      chk("noena_done", done_cnt - d0, 0);
      bk_ena = 1'b1;
      @(negedge clk_sys);

      // ---- save slot 1, RAM write during sector 5 ----
      rec_wr.delete(); rec_lba.delete();
      d0 = done_cnt;
      slot = 2'd1;
      save_req = 1'b1;
      @(negedge clk_sys);
      chk("save_first_wr", sd_wr, 1);
      chk("save_first_lba", sd_lba, 32'h10);
      save_req = 1'b0;
      run_op(3000, 6, 1, 1'b0, ll);
      repeat (4) @(negedge clk_sys);
      check_seq("save", 16, 1'b1, 1);
      chk("save_dirty", bk_dirty, 1);
      chk("save_done_pulses", done_cnt - d0, 1);

      // ---- format alone ----
      format_req = 1'b1;
      w0 = we_cnt;
      check_fmt("fmt");
      format_req = 1'b0;
      @(negedge clk_sys);
      chk("fmt_we_cycles", we_cnt - w0, 4);
      chk("fmt_dirty", bk_dirty, 1);

      // ---- load and format in the same cycle: format wins, load dropped ----
      rec_wr.delete(); rec_lba.delete();
      load_req = 1'b1;
      format_req = 1'b1;
      check_fmt("fmtload");
      load_req = 1'b0;
      format_req = 1'b0;
      repeat (10) @(negedge clk_sys);
      chk("fmtload_no_rd", rec_lba.size(), 0);
      chk("fmtload_busy", bk_busy, 0);

      // ---- format during a save: save completes, then format ----
      rec_wr.delete(); rec_lba.delete();
      s = $urandom_range(0, 3);
      slot = 2'(s);
      save_req = 1'b1;
      @(negedge clk_sys);
      save_req = 1'b0;
      run_op(3000, 3, 2, 1'b0, ll);
      chk("pend_busy_at_done", bk_busy, 1);
      check_fmt("pendfmt");
      check_seq("pendsave", 16, 1'b1, s);

      // ---- reset during sector 3 of a load ----
      rec_wr.delete(); rec_lba.delete();
      hps_chk = 1'b0;
      s = $urandom_range(1, 3);
      slot = 2'(s);
      load_req = 1'b1;
      @(negedge clk_sys);
      load_req = 1'b0;
      for (int i = 0; i < 2000 && rec_lba.size() < 4; i++) @(negedge clk_sys);
      chk("rst_mid_reached", rec_lba.size(), 4);
      reset = 1'b1;
      @(negedge clk_sys);
      chk("rstmid_rd", sd_rd, 0);
      chk("rstmid_loading", bk_loading, 0);
      chk("rstmid_lba", sd_lba, 0);
      chk("rstmid_idle", bk_busy, 0);
      reset = 1'b0;
      for (int i = 0; i < 100 && sd_ack; i++) @(negedge clk_sys);
      repeat (5) @(negedge clk_sys);
      chk("rstmid_no_more", rec_lba.size(), 4);
      hps_chk = 1'b1;

      // ---- bk_ena dropped mid-save ----
      rec_wr.delete(); rec_lba.delete();
      d0 = done_cnt;
      s = $urandom_range(0, 3);
      slot = 2'(s);
      save_req = 1'b1;
      @(negedge clk_sys);
      save_req = 1'b0;
      run_op(3000, 7, 3, 1'b0, ll);
      repeat (10) @(negedge clk_sys);
      check_seq("enadrop", 7, 1'b1, s);
      chk("enadrop_done", done_cnt - d0, 1);
      chk("enadrop_busy", bk_busy, 0);
      bk_ena = 1'b1;

      // ---- handshake timing seen across all transfers ----
      chk("ack_rise_latency", lat_bad, 0);
      chk("ack_fall_gap", gap_bad, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
